// File: rtl/timestep_controller_pkg.sv
// Shared types and field positions for the timestep sequencing FSM.
package tsc_pkg;

  localparam int IW = 10;
  localparam int TW = 2;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 8;
  localparam int RX_MSB = 7;
  localparam int RX_LSB = 6;
  localparam int RY_MSB = 5;
  localparam int RY_LSB = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } opcode_t;

  typedef enum logic [TW-1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

endpackage

// File: rtl/timestep_controller_rise_detect.sv
// One-flop rising-edge pulse generator for already-synchronised levels.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level_i;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/timestep_controller.sv
// Instruction sequencer: latches INSTR on an EXEC rise and walks T0..T3 driving
// bus/register-file/ALU enables. Optional macro SINGLE_STEP_EN gates T1..T3 on STEP rises.
module timestep_controller
  import tsc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] INSTR,
  input  logic          EXEC,
  input  logic          STEP,
  output logic [TW-1:0] TIME,
  output logic          DONE,
  output logic          EXT_OUT,
  output logic          R_OUT,
  output logic [1:0]    RD_ADDR,
  output logic          R_IN,
  output logic [1:0]    WR_ADDR,
  output logic          A_IN,
  output logic          G_IN,
  output logic          ALU_SUB,
  output logic          G_OUT
);

  tstep_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          exec_rise;
  logic          advance;

  logic          r_in_c, a_in_c, g_in_c;
  opcode_t       op;
  logic [1:0]    rx, ry;
  logic          unused_ir;

  rise_detect u_exec_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (EXEC),
    .rise_o  (exec_rise)
  );

`ifdef SINGLE_STEP_EN
  logic step_rise;

  rise_detect u_step_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (STEP),
    .rise_o  (step_rise)
  );

  assign advance = step_rise;
`else
  logic unused_step;
  assign unused_step = STEP;
  assign advance     = 1'b1;
`endif

  assign op        = opcode_t'(ir_q[OP_MSB:OP_LSB]);
  assign rx        = ir_q[RX_MSB:RX_LSB];
  assign ry        = ir_q[RY_MSB:RY_LSB];
  assign unused_ir = ^ir_q[3:0];

  // Controls decode only from registered state and IR, never from INSTR.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    DONE    = 1'b0;
    EXT_OUT = 1'b0;
    R_OUT   = 1'b0;
    RD_ADDR = 2'd0;
    r_in_c  = 1'b0;
    WR_ADDR = 2'd0;
    a_in_c  = 1'b0;
    g_in_c  = 1'b0;
    ALU_SUB = 1'b0;
    G_OUT   = 1'b0;
    unique case (state_q)
      T0: begin
        if (exec_rise) begin
          ir_d    = INSTR;
          state_d = T1;
        end
      end
      T1: begin
        unique case (op)
          OP_LOAD: begin
            EXT_OUT = 1'b1;
            r_in_c  = 1'b1;
            WR_ADDR = rx;
            DONE    = 1'b1;
            if (advance) state_d = T0;
          end
          OP_MOV: begin
            R_OUT   = 1'b1;
            RD_ADDR = ry;
            r_in_c  = 1'b1;
            WR_ADDR = rx;
            DONE    = 1'b1;
            if (advance) state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            R_OUT   = 1'b1;
            RD_ADDR = rx;
            a_in_c  = 1'b1;
            if (advance) state_d = T2;
          end
        endcase
      end
      T2: begin
        R_OUT   = 1'b1;
        RD_ADDR = ry;
        g_in_c  = 1'b1;
        ALU_SUB = op[0];
        if (advance) state_d = T3;
      end
      T3: begin
        G_OUT   = 1'b1;
        r_in_c  = 1'b1;
        WR_ADDR = rx;
        DONE    = 1'b1;
        if (advance) state_d = T0;
      end
    endcase
  end

  // Under single-step, holding a timestep must not repeat its register writes.
  assign R_IN = r_in_c & advance;
  assign A_IN = a_in_c & advance;
  assign G_IN = g_in_c & advance;
  assign TIME = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule
